// File: rtl/regfile_2r1w_pc_if.sv
// regfile_2r1w_pc_if: bundle of decode / writeback / fetch signals around the
// register file.
//
// Parameters: DATA_W (register and PC width), ADDR_W (register address width).
//
// Signals (directions as seen from the register file, modport "slave"):
//   rs1_addr, rs2_addr   in   read addresses
//   rs1_data, rs2_data   out  read data (combinational)
//   rs1_busy, rs2_busy   out  pending bit of the addressed register
//   wr_en/wr_addr/wr_data  in  writeback port
//   mark_en/mark_addr    in   claim a register for an in-flight producer
//   pc_stall, pc_load, pc_load_val  in  program counter control
//   pc_out               out  current program counter
// The "master" modport is the pipeline side that drives addresses and controls.
interface regfile_2r1w_pc_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] rs1_addr;
  logic [DATA_W-1:0] rs1_data;
  logic              rs1_busy;
  logic [ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0] rs2_data;
  logic              rs2_busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              mark_en;
  logic [ADDR_W-1:0] mark_addr;
  logic              pc_stall;
  logic              pc_load;
  logic [DATA_W-1:0] pc_load_val;
  logic [DATA_W-1:0] pc_out;

  modport master (
    output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, mark_en, mark_addr,
           pc_stall, pc_load, pc_load_val,
    input  rs1_data, rs1_busy, rs2_data, rs2_busy, pc_out
  );

  modport slave (
    input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, mark_en, mark_addr,
           pc_stall, pc_load, pc_load_val,
    output rs1_data, rs1_busy, rs2_data, rs2_busy, pc_out
  );
endinterface

// File: rtl/regfile_2r1w_pc.sv
// regfile_2r1w_pc: general-purpose register file with two combinational read
// ports, one synchronous write port, a per-register pending scoreboard and the
// fetch program counter.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (clears registers, pending bits, PC)
//   bus    regfile_2r1w_pc_if.slave: read ports, write port, mark port, PC
//
// Addresses >= NUM_REGS read as 0 / not busy; writes and marks to them are
// dropped.
//
// Optional feature, macro REGFILE_BYPASS_EN: when defined, a read port whose
// address matches an in-range write in the same cycle returns wr_data, and its
// busy bit reflects only a same-cycle mark to that address. When undefined,
// written data becomes visible the cycle after the write edge.
module regfile_2r1w_pc #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 4,
  parameter int                 NUM_REGS = 16,
  parameter int                 PC_STEP  = 4,
  parameter logic [DATA_W-1:0]  PC_RESET = '0
) (
  input logic              clk,
  input logic              reset,
  regfile_2r1w_pc_if.slave bus
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [DATA_W-1:0]   pc_q;

  // NOTE: the register array is reset like any other state so nothing ever
  // reads X; with a small register file this is cheap and keeps reads defined.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      pending <= '0;
    end else begin
      // Address decode by comparison against each implemented index: an
      // out-of-range address matches nothing, so it is dropped without ever
      // indexing the array.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (bus.wr_en && bus.wr_addr == ADDR_W'(i)) begin
          // NOTE: non-blocking assignment for all clocked state so every
          // register samples pre-edge values regardless of statement order.
          regs[i] <= bus.wr_data;
        end
        // A mark on the same edge as the write wins: the new producer owns it.
        if (bus.mark_en && bus.mark_addr == ADDR_W'(i)) begin
          pending[i] <= 1'b1;
        end else if (bus.wr_en && bus.wr_addr == ADDR_W'(i)) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // Program counter: load beats stall, stall beats increment; wraps silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= PC_RESET;
    end else if (bus.pc_load) begin
      pc_q <= bus.pc_load_val;
    end else if (!bus.pc_stall) begin
      pc_q <= pc_q + DATA_W'(PC_STEP);
    end
  end

  assign bus.pc_out = pc_q;

  logic [DATA_W-1:0] rs1_stored, rs2_stored;
  logic              rs1_pend, rs2_pend;

  // NOTE: every always_comb output gets a default first; otherwise an address
  // that matches no register would hold the previous value and infer a latch.
  always_comb begin
    rs1_stored = '0;
    rs2_stored = '0;
    rs1_pend   = 1'b0;
    rs2_pend   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.rs1_addr == ADDR_W'(i)) begin
        rs1_stored = regs[i];
        rs1_pend   = pending[i];
      end
      if (bus.rs2_addr == ADDR_W'(i)) begin
        rs2_stored = regs[i];
        rs2_pend   = pending[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  localparam logic [ADDR_W:0] NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);

  logic wr_live;
  logic rs1_hit, rs2_hit;

  // Only an in-range write may forward; an ignored write must stay invisible.
  assign wr_live = bus.wr_en && ({1'b0, bus.wr_addr} < NUM_REGS_X);
  assign rs1_hit = wr_live && (bus.wr_addr == bus.rs1_addr);
  assign rs2_hit = wr_live && (bus.wr_addr == bus.rs2_addr);

  // A forwarded value is complete unless a new producer claims the register
  // on the same edge.
  assign bus.rs1_data = rs1_hit ? bus.wr_data : rs1_stored;
  assign bus.rs2_data = rs2_hit ? bus.wr_data : rs2_stored;
  assign bus.rs1_busy = rs1_hit ? (bus.mark_en && bus.mark_addr == bus.rs1_addr) : rs1_pend;
  assign bus.rs2_busy = rs2_hit ? (bus.mark_en && bus.mark_addr == bus.rs2_addr) : rs2_pend;
`else
  assign bus.rs1_data = rs1_stored;
  assign bus.rs2_data = rs2_stored;
  assign bus.rs1_busy = rs1_pend;
  assign bus.rs2_busy = rs2_pend;
`endif

endmodule

// File: tb/tb_regfile_2r1w_pc.sv
// tb_regfile_2r1w_pc: directed bench for regfile_2r1w_pc. Instance dut_a uses
// the default 16 registers; dut_b uses NUM_REGS=12 for the out-of-range cases.
// Expected values are queued when stimulus is applied and compared when the
// corresponding output is sampled.
module tb_regfile_2r1w_pc;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_2r1w_pc_if #(.DATA_W(32), .ADDR_W(4)) ifa ();
  regfile_2r1w_pc_if #(.DATA_W(32), .ADDR_W(4)) ifb ();

  regfile_2r1w_pc #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(16)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  regfile_2r1w_pc #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(12)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic want(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check(input logic [31:0] obs);
    sb_entry_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Advance past the next rising edge, leaving time to drive and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    ifa.rs1_addr = '0; ifa.rs2_addr = '0; ifa.wr_en = 1'b0; ifa.wr_addr = '0;
    ifa.wr_data = '0; ifa.mark_en = 1'b0; ifa.mark_addr = '0;
    ifa.pc_stall = 1'b0; ifa.pc_load = 1'b0; ifa.pc_load_val = '0;
    ifb.rs1_addr = '0; ifb.rs2_addr = '0; ifb.wr_en = 1'b0; ifb.wr_addr = '0;
    ifb.wr_data = '0; ifb.mark_en = 1'b0; ifb.mark_addr = '0;
    ifb.pc_stall = 1'b0; ifb.pc_load = 1'b0; ifb.pc_load_val = '0;

    // Reset state: every address on both ports reads 0, not busy.
    for (int a = 0; a < 16; a++) begin
      ifa.rs1_addr = 4'(a);
      ifa.rs2_addr = 4'(15 - a);
      #1;
      want($sformatf("reset_rs1_data[%0d]", a), 32'h0); check(ifa.rs1_data);
      want($sformatf("reset_rs1_busy[%0d]", a), 32'h0); check({31'b0, ifa.rs1_busy});
      want($sformatf("reset_rs2_data[%0d]", 15 - a), 32'h0); check(ifa.rs2_data);
      want($sformatf("reset_rs2_busy[%0d]", 15 - a), 32'h0); check({31'b0, ifa.rs2_busy});
    end
    want("reset_pc", 32'h0); check(ifa.pc_out);

    // Release reset away from an edge; first edge afterwards increments.
    @(negedge clk);
    reset = 1'b1;
    #1;
    want("pc_after_release", 32'h0); check(ifa.pc_out);
    step(); want("pc_inc_1", 32'h4); check(ifa.pc_out);
    step(); want("pc_inc_2", 32'h8); check(ifa.pc_out);

    // Stall holds; load overrides stall.
    ifa.pc_stall = 1'b1;
    step(); want("pc_stall_1", 32'h8); check(ifa.pc_out);
    step(); want("pc_stall_2", 32'h8); check(ifa.pc_out);
    ifa.pc_load = 1'b1; ifa.pc_load_val = 32'h100;
    step(); want("pc_load_over_stall", 32'h100); check(ifa.pc_out);
    ifa.pc_load = 1'b0;
    step(); want("pc_stall_after_load", 32'h100); check(ifa.pc_out);

    // Write r5; same-cycle read sees old value unless forwarding is built in.
    ifa.wr_en = 1'b1; ifa.wr_addr = 4'd5; ifa.wr_data = 32'hDEADBEEF;
    ifa.rs1_addr = 4'd5; ifa.rs2_addr = 4'd5;
    // dut_b: out-of-range write/mark to r13, in-range write/mark to r11.
    ifb.wr_en = 1'b1; ifb.wr_addr = 4'd13; ifb.wr_data = 32'h1234;
    ifb.mark_en = 1'b1; ifb.mark_addr = 4'd13; ifb.rs1_addr = 4'd13; ifb.rs2_addr = 4'd11;
    #1;
    want("r5_same_cycle", BYP ? 32'hDEADBEEF : 32'h0); check(ifa.rs1_data);
    want("b_r13_no_bypass", 32'h0); check(ifb.rs1_data);
    step();
    ifa.wr_en = 1'b0;
    ifb.wr_en = 1'b0; ifb.mark_en = 1'b0;
    #1;
    want("r5_rs1", 32'hDEADBEEF); check(ifa.rs1_data);
    want("r5_rs2", 32'hDEADBEEF); check(ifa.rs2_data);
    want("b_r13_data", 32'h0); check(ifb.rs1_data);
    want("b_r13_busy", 32'h0); check({31'b0, ifb.rs1_busy});
    want("b_r11_data_before", 32'h0); check(ifb.rs2_data);

    // In-range boundary register on dut_b still works.
    ifb.wr_en = 1'b1; ifb.wr_addr = 4'd11; ifb.wr_data = 32'hABCD;
    ifb.mark_en = 1'b1; ifb.mark_addr = 4'd11;
    step();
    ifb.wr_en = 1'b0; ifb.mark_en = 1'b0;
    #1;
    want("b_r11_data", 32'hABCD); check(ifb.rs2_data);
    want("b_r11_busy", 32'h1); check({31'b0, ifb.rs2_busy});

    // r0 is an ordinary register.
    ifa.wr_en = 1'b1; ifa.wr_addr = 4'd0; ifa.wr_data = 32'h11112222;
    step();
    ifa.wr_en = 1'b0; ifa.rs1_addr = 4'd0;
    #1;
    want("r0_written", 32'h11112222); check(ifa.rs1_data);

    // Mark r3: busy only after the edge.
    ifa.mark_en = 1'b1; ifa.mark_addr = 4'd3; ifa.rs1_addr = 4'd3;
    #1;
    want("r3_busy_before_mark_edge", 32'h0); check({31'b0, ifa.rs1_busy});
    step();
    ifa.mark_en = 1'b0;
    #1;
    want("r3_busy_after_mark", 32'h1); check({31'b0, ifa.rs1_busy});

    // Write r3 clears busy.
    ifa.wr_en = 1'b1; ifa.wr_addr = 4'd3; ifa.wr_data = 32'h55;
    #1;
    want("r3_wr_same_data", BYP ? 32'h55 : 32'h0); check(ifa.rs1_data);
    want("r3_wr_same_busy", BYP ? 32'h0 : 32'h1); check({31'b0, ifa.rs1_busy});
    step();
    ifa.wr_en = 1'b0;
    #1;
    want("r3_data_after_wr", 32'h55); check(ifa.rs1_data);
    want("r3_busy_after_wr", 32'h0); check({31'b0, ifa.rs1_busy});

    // Mark and write r3 on the same edge: data lands, pending stays set.
    ifa.wr_en = 1'b1; ifa.wr_addr = 4'd3; ifa.wr_data = 32'h66;
    ifa.mark_en = 1'b1; ifa.mark_addr = 4'd3;
    #1;
    want("r3_markwr_same_data", BYP ? 32'h66 : 32'h55); check(ifa.rs1_data);
    want("r3_markwr_same_busy", BYP ? 32'h1 : 32'h0); check({31'b0, ifa.rs1_busy});
    step();
    ifa.wr_en = 1'b0; ifa.mark_en = 1'b0;
    #1;
    want("r3_markwr_data", 32'h66); check(ifa.rs1_data);
    want("r3_markwr_busy", 32'h1); check({31'b0, ifa.rs1_busy});

    // Mark r4 and write r6 on the same edge: both happen.
    ifa.mark_en = 1'b1; ifa.mark_addr = 4'd4;
    ifa.wr_en = 1'b1; ifa.wr_addr = 4'd6; ifa.wr_data = 32'h0BADF00D;
    step();
    ifa.mark_en = 1'b0; ifa.wr_en = 1'b0;
    ifa.rs1_addr = 4'd4; ifa.rs2_addr = 4'd6;
    #1;
    want("r4_busy", 32'h1); check({31'b0, ifa.rs1_busy});
    want("r4_data", 32'h0); check(ifa.rs1_data);
    want("r6_data", 32'h0BADF00D); check(ifa.rs2_data);
    want("r6_busy", 32'h0); check({31'b0, ifa.rs2_busy});

    // PC wrap at 2**32.
    ifa.pc_load = 1'b1; ifa.pc_load_val = 32'hFFFFFFFC;
    step();
    ifa.pc_load = 1'b0; ifa.pc_stall = 1'b0;
    #1;
    want("pc_load_top", 32'hFFFFFFFC); check(ifa.pc_out);
    step(); want("pc_wrap", 32'h0); check(ifa.pc_out);
    step(); want("pc_after_wrap", 32'h4); check(ifa.pc_out);

    // Reach PC=0x20 with r7=0xA5, then reset mid-cycle.
    ifa.pc_load = 1'b1; ifa.pc_load_val = 32'h1C;
    ifa.wr_en = 1'b1; ifa.wr_addr = 4'd7; ifa.wr_data = 32'hA5;
    step();
    ifa.pc_load = 1'b0; ifa.wr_en = 1'b0;
    #1;
    want("pc_load_1c", 32'h1C); check(ifa.pc_out);
    step();
    ifa.rs1_addr = 4'd7; ifa.rs2_addr = 4'd3;
    #1;
    want("pc_20", 32'h20); check(ifa.pc_out);
    want("r7_before_reset", 32'hA5); check(ifa.rs1_data);
    want("r3_busy_before_reset", 32'h1); check({31'b0, ifa.rs2_busy});
    #1;
    reset = 1'b0;
    #1;
    want("pc_async_reset", 32'h0); check(ifa.pc_out);
    want("r7_async_reset", 32'h0); check(ifa.rs1_data);
    want("r3_busy_async_reset", 32'h0); check({31'b0, ifa.rs2_busy});
    want("r3_data_async_reset", 32'h0); check(ifa.rs2_data);
    @(negedge clk);
    reset = 1'b1;
    #1;
    want("pc_after_second_release", 32'h0); check(ifa.pc_out);
    step(); want("pc_first_inc_after_reset", 32'h4); check(ifa.pc_out);

    // Write r9 while rs2 reads it.
    ifa.wr_en = 1'b1; ifa.wr_addr = 4'd9; ifa.wr_data = 32'h77; ifa.rs2_addr = 4'd9;
    #1;
    want("r9_same_cycle", BYP ? 32'h77 : 32'h0); check(ifa.rs2_data);
    step();
    ifa.wr_en = 1'b0;
    #1;
    want("r9_next_cycle", 32'h77); check(ifa.rs2_data);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
